vga_text_scanner: RTL and testbench
===================================

# vga_text_scanner

Raster-scan initiator for the character buffer's read interface. It generates 640x480@60 VGA timing and issues per-pixel character and offset read addresses to the character buffer. It then consumes the buffer's one-cycle-latency `read_lit` / `out_of_bounds` response and drives registered sync and RGB pins. It sits between the character buffer and the board's VGA DAC, with `clk` running at the pixel rate (25.175 MHz nominal).

## Interface
- `P_FG`, default 12'hFFF: RGB444 color for lit pixels.
- `P_BG`, default 12'h000: RGB444 color for unlit in-bounds pixels.
- `P_BORDER`, default 12'h00F: RGB444 color for out-of-bounds visible pixels (used only with the border feature).
- `clk`, input, 1: pixel clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `read_hchar`, output, 7: character column, `hcount[9:3]`.
- `read_vchar`, output, 5: character row, `vcount[8:4]`.
- `read_hoffset`, output, 3: pixel within character, `hcount[2:0]`.
- `read_voffset`, output, 4: line within character, `vcount[3:0]`.
- `read_lit`, input, 1: buffer response, valid one cycle after the address.
- `out_of_bounds`, input, 1: buffer response, valid one cycle after the address.
- `vga_hsync`, output, 1: horizontal sync, active-low.
- `vga_vsync`, output, 1: vertical sync, active-low.
- `vga_rgb`, output, 12: `{r[3:0], g[3:0], b[3:0]}`.
- `frame_start`, output, 1: one-cycle pulse aligned with pin pixel (0,0).

## Operation
- `hcount` runs 0..799; `vcount` runs 0..524. Both are 10-bit registered counters.
- `hcount` wraps 799 -> 0. On that wrap, `vcount` increments; `vcount` wraps 524 -> 0 at the `hcount` 799 -> 0 edge.
- Horizontal regions: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical regions: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- `active` = (`hcount` < 640) & (`vcount` < 480).
- Read address outputs are combinational from the counters when `active`. They are forced to all-zero during blanking.
- Pixel decision, in the cycle the response is valid:
  - blanking -> 12'h000;
  - else `read_lit` -> `P_FG`;
  - else `out_of_bounds` -> per Configuration;
  - else -> `P_BG`.
- `read_lit` takes priority over `out_of_bounds`. The buffer already forces `read_lit` = 0 when out of bounds.

## Timing
- Pipeline stage 0: counters and address outputs at cycle t.
- Stage 1: `active`, `hsync_n`, `vsync_n`, and `is_origin` registered at end of t. This aligns them with `read_lit` / `out_of_bounds` during t+1.
- Stage 2: `vga_rgb`, `vga_hsync`, `vga_vsync`, and `frame_start` registered at end of t+1. They are visible at t+2.
- Total latency from counter value to pins: 2 cycles. Sync and color stay mutually aligned.
- Reset values:
  - counters 0;
  - all stage-1 and stage-2 registers at blanking: syncs 1, `vga_rgb` 0, `frame_start` 0, `active` 0;
  - address outputs 0, since the counters are (0,0).
- Post-reset sequence: the first cycle after `rst` deasserts presents address (0,0). `frame_start` = 1 two cycles later, together with the first pixel color.
- Reset mid-frame: all state returns to the values above on the next edge. No partial-line continuation.
- Frame period: 800 x 525 = 420000 cycles. `frame_start` pulses exactly once per period.

## Configuration
- `VGA_TEXT_SCANNER_BORDER_EN` defined: visible pixels with `out_of_bounds` = 1 and `read_lit` = 0 show `P_BORDER`.
- Undefined: those pixels show `P_BG`. The `P_BORDER` parameter is present but ignored.
- Timing is identical in both builds.

## Structure
- Package `vga_text_pkg` holds:
  - all eight porch/sync/visible localparams;
  - `H_TOTAL` = 800 and `V_TOTAL` = 525;
  - `typedef logic [11:0] rgb_t`.
- Sub-module `vga_timing_counter` holds the h/v counters, the `active` decode, the raw sync decode, and the origin flag.
- The top level handles address slicing, response alignment, and color muxing.

## Test plan
- Reset, then hold `rst` for 3 cycles: `vga_hsync` = 1, `vga_vsync` = 1, `vga_rgb` = 0, `frame_start` = 0, address = 0. After release, `frame_start` = 1 exactly 2 cycles later.
- Model buffer that returns `read_lit` = 1 only for address (hchar 1, hoffset 3, vchar 0, voffset 0): `vga_rgb` = `P_FG` on exactly one pin pixel, at the cycle for `hcount` 11, `vcount` 0, plus 2. All other visible pixels = `P_BG`.
- Sync placement: `vga_hsync` low for 96 cycles, starting 2 cycles after `hcount` = 656. `vga_vsync` low for 2 lines, starting 2 cycles after (`hcount` 0, `vcount` 490). `vga_rgb` = 0 throughout blanking even if `read_lit` = 1.
- `out_of_bounds` = 1 for `read_hchar` >= 32: with the macro, pixel x = 256..639 = `P_BORDER`; without it, `P_BG`. With `read_lit` = 1 and `out_of_bounds` = 1 forced together, the pixel = `P_FG`.
- Run 2 full frames: consecutive `frame_start` pulses are 420000 cycles apart. Addresses at `vcount` 479, `hcount` 639 read hchar 79, hoffset 7, vchar 29, voffset 15.
- Assert `rst` at `vcount` 200, `hcount` 300 for 1 cycle: the next cycle's address is (0,0), syncs are 1, and `frame_start` pulses 2 cycles after release.

Source files
------------

// File: rtl/vga_text_pkg.sv
`timescale 1ns/1ps
// Shared 640x480@60 raster constants and the RGB444 pixel type for the VGA text scanner.
package vga_text_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;

  localparam logic [9:0] H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync windows as half-open ranges [start, end).
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [11:0] rgb_t;

endpackage

// File: rtl/vga_timing_counter.sv
`timescale 1ns/1ps
// Free-running 800x525 raster counters with combinational visible, raw sync and origin decodes.
// Decodes are valid in the same cycle as the counter value; the caller registers them.
module vga_timing_counter
  import vga_text_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       is_origin
);

  logic line_end;
  logic frame_end;

  assign line_end  = (hcount == H_TOTAL - 10'd1);
  assign frame_end = (vcount == V_TOTAL - 10'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (line_end) begin
      hcount <= '0;
      vcount <= frame_end ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  assign active    = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
  assign hsync_n   = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
  // Vertical sync covers whole lines, so it depends on vcount alone.
  assign vsync_n   = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
  assign is_origin = (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/vga_text_scanner.sv
`timescale 1ns/1ps
// Raster-scan initiator: 640x480@60 timing, character-buffer read addresses, registered VGA pins (2-cycle latency).
// Build option VGA_TEXT_SCANNER_BORDER_EN paints visible out-of-bounds pixels with P_BORDER instead of P_BG.
module vga_text_scanner
  import vga_text_pkg::*;
#(
  parameter rgb_t P_FG     = 12'hFFF,
  parameter rgb_t P_BG     = 12'h000,
  parameter rgb_t P_BORDER = 12'h00F
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] read_hchar,
  output logic [4:0] read_vchar,
  output logic [2:0] read_hoffset,
  output logic [3:0] read_voffset,
  input  logic       read_lit,
  input  logic       out_of_bounds,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output rgb_t       vga_rgb,
  output logic       frame_start
);

`ifdef VGA_TEXT_SCANNER_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif
  localparam rgb_t OOB_COLOR = BORDER_EN ? P_BORDER : P_BG;

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic       hsync_n;
  logic       vsync_n;
  logic       is_origin;

  vga_timing_counter u_timing (
    .clk       (clk),
    .rst       (rst),
    .hcount    (hcount),
    .vcount    (vcount),
    .active    (active),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .is_origin (is_origin)
  );

  // Rows beyond 511 are never visible, so the counter MSB never reaches an address.
  logic unused_vcount_msb;
  assign unused_vcount_msb = vcount[9];

  assign read_hchar   = active ? hcount[9:3] : '0;
  assign read_vchar   = active ? vcount[8:4] : '0;
  assign read_hoffset = active ? hcount[2:0] : '0;
  assign read_voffset = active ? vcount[3:0] : '0;

  // Stage 1 lines the raster decodes up with the buffer's one-cycle response.
  logic active_q;
  logic hsync_q;
  logic vsync_q;
  logic origin_q;
  rgb_t pixel;

  always_comb begin
    pixel = '0;
    if (active_q) begin
      if (read_lit) begin
        pixel = P_FG;
      end else if (out_of_bounds) begin
        pixel = OOB_COLOR;
      end else begin
        pixel = P_BG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      origin_q    <= 1'b0;
      vga_rgb     <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      active_q    <= active;
      hsync_q     <= hsync_n;
      vsync_q     <= vsync_n;
      origin_q    <= is_origin;
      vga_rgb     <= pixel;
      vga_hsync   <= hsync_q;
      vga_vsync   <= vsync_q;
      frame_start <= origin_q;
    end
  end

endmodule

// File: tb/tb_vga_text_scanner.sv
`timescale 1ns/1ps
// Bench for vga_text_scanner: a raster-position model predicts addresses and pins every cycle.
module tb_vga_text_scanner;

  localparam logic [11:0] FG     = 12'hABC;
  localparam logic [11:0] BG     = 12'h123;
  localparam logic [11:0] BORDER = 12'h0F5;
`ifdef VGA_TEXT_SCANNER_BORDER_EN
  localparam logic [11:0] OOB_EXP = BORDER;
`else
  localparam logic [11:0] OOB_EXP = BG;
`endif
  // Pin record layout: {hsync, vsync, frame_start, rgb}.
  localparam logic [14:0] BLANK = {1'b1, 1'b1, 1'b0, 12'h000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  read_hchar;
  logic [4:0]  read_vchar;
  logic [2:0]  read_hoffset;
  logic [3:0]  read_voffset;
  logic        read_lit = 1'b0;
  logic        out_of_bounds = 1'b0;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [11:0] vga_rgb;
  logic        frame_start;

  vga_text_scanner #(.P_FG(FG), .P_BG(BG), .P_BORDER(BORDER)) dut (
    .clk           (clk),
    .rst           (rst),
    .read_hchar    (read_hchar),
    .read_vchar    (read_vchar),
    .read_hoffset  (read_hoffset),
    .read_voffset  (read_voffset),
    .read_lit      (read_lit),
    .out_of_bounds (out_of_bounds),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_rgb       (vga_rgb),
    .frame_start   (frame_start)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model raster position for the cycle about to be checked, plus the two-deep pin delay.
  int          mh = 0;
  int          mv = 0;
  int          mode = 0;
  int          cyc = 0;
  longint      vcyc = 0;
  logic [14:0] d1 = BLANK;
  logic [14:0] d2 = BLANK;
  logic        nxt_lit = 1'b0;
  logic        nxt_oob = 1'b0;
  logic [9:0]  jump_h = '0;
  logic [9:0]  jump_v = '0;

  int          fg_cnt = 0, fg_cyc = -1;
  int          hs_cnt = 0, hs_first = -1;
  int          vs_cnt = 0, vs_first = -1;
  int          fs_n = 0, fs_cyc = -1;
  longint      fs_vt [4];
  int          probe_h = -1, probe_v = -1, probe_at = -1;
  logic [11:0] probe_rgb = 12'hEEE;
  logic [18:0] addr_seen = '0;
  logic [18:0] addr_last;
  int          rel, j, rel2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic vis_at(input int h, input int v);
    return (h < 640) && (v < 480);
  endfunction

  function automatic logic [18:0] addr_at(input int h, input int v);
    if (!vis_at(h, v)) return '0;
    return {7'(h / 8), 5'(v / 16), 3'(h % 8), 4'(v % 16)};
  endfunction

  function automatic logic [14:0] pins_at(input int h, input int v, input logic lit, input logic oob);
    logic [11:0] c;
    if (!vis_at(h, v)) c = 12'h000;
    else if (lit)      c = FG;
    else if (oob)      c = OOB_EXP;
    else               c = BG;
    return {!(h >= 656 && h < 752), !(v >= 490 && v < 492), (h == 0 && v == 0), c};
  endfunction

  // Character-buffer stand-in: decides the response for the address of position (h, v).
  task automatic respond(input int h, input int v);
    logic [18:0] a;
    a = addr_at(h, v);
    case (mode)
      0: begin
        nxt_lit = (a == {7'd1, 5'd0, 3'd3, 4'd0});
        nxt_oob = 1'b0;
      end
      1: begin
        nxt_oob = (a[18:12] >= 7'd32);
        nxt_lit = !nxt_oob && ($urandom_range(3) == 0);
      end
      2: begin
        nxt_lit = 1'($urandom_range(1));
        nxt_oob = 1'($urandom_range(1));
      end
      default: begin
        nxt_lit = 1'b1;
        nxt_oob = 1'b1;
      end
    endcase
  endtask

  task automatic clear_stats();
    fg_cnt = 0; fg_cyc = -1;
    hs_cnt = 0; hs_first = -1;
    vs_cnt = 0; vs_first = -1;
  endtask

  // One pixel clock: drive response/reset, optionally move the raster, then check at the falling edge.
  task automatic step(input logic do_rst, input logic do_jump, input int jh, input int jv);
    @(posedge clk);
    #1;
    read_lit      = nxt_lit;
    out_of_bounds = nxt_oob;
    rst           = do_rst;
    if (do_jump) begin
      vcyc += longint'((jv * 800 + jh) - (mv * 800 + mh));
      jump_h = 10'(jh);
      jump_v = 10'(jv);
      force dut.u_timing.hcount = jump_h;
      force dut.u_timing.vcount = jump_v;
      release dut.u_timing.hcount;
      release dut.u_timing.vcount;
      mh = jh;
      mv = jv;
    end
    @(negedge clk);
    cyc++;
    vcyc++;
    addr_last = {read_hchar, read_vchar, read_hoffset, read_voffset};
    check("addr", 32'(addr_last), 32'(addr_at(mh, mv)));
    check("pins", 32'({vga_hsync, vga_vsync, frame_start, vga_rgb}), 32'(d2));

    if (vga_rgb == FG) begin fg_cnt++; fg_cyc = cyc; end
    if (!vga_hsync) begin if (hs_cnt == 0) hs_first = cyc; hs_cnt++; end
    if (!vga_vsync) begin if (vs_cnt == 0) vs_first = cyc; vs_cnt++; end
    if (frame_start) begin
      if (fs_n < 4) fs_vt[fs_n] = vcyc;
      fs_n++;
      fs_cyc = cyc;
    end
    if (cyc == probe_at) probe_rgb = vga_rgb;
    if (mh == probe_h && mv == probe_v) probe_at = cyc + 2;
    if (mh == 639 && mv == 479) addr_seen = addr_last;

    respond(mh, mv);
    if (do_rst) begin
      d1 = BLANK;
      d2 = BLANK;
      mh = 0;
      mv = 0;
    end else begin
      d2 = d1;
      d1 = pins_at(mh, mv, nxt_lit, nxt_oob);
      mh++;
      if (mh == 800) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end
    end
  endtask

  initial begin
    logic [18:0] corner;
    corner = {7'd79, 5'd29, 3'd7, 4'd15};
    repeat (2) @(posedge clk);

    // Reset held for three cycles: pins parked at blanking, address (0,0).
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0);
    check("rst_hsync", 32'(vga_hsync), 32'd1);
    check("rst_vsync", 32'(vga_vsync), 32'd1);
    check("rst_rgb", 32'(vga_rgb), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_addr", 32'(addr_last), 32'd0);

    // Single lit glyph pixel at (11,0); two full lines for horizontal sync placement.
    clear_stats();
    mode = 0;
    rel = cyc + 1;
    for (int i = 0; i < 1602; i++) step(1'b0, 1'b0, 0, 0);
    check("frame_start_after_release", 32'(fs_cyc), 32'(rel + 2));
    check("fg_pixel_count", 32'(fg_cnt), 32'd1);
    check("fg_pixel_cycle", 32'(fg_cyc), 32'(rel + 13));
    check("hsync_first_low", 32'(hs_first), 32'(rel + 658));
    check("hsync_low_two_lines", 32'(hs_cnt), 32'd192);

    // Columns 32+ out of bounds with random in-bounds glyphs.
    mode = 1;
    probe_h = 256; probe_v = 5;
    for (int i = 0; i < 16000; i++) step(1'b0, 1'b0, 0, 0);
    check("oob_pixel_256", 32'(probe_rgb), 32'(OOB_EXP));

    // Fully random responses, including lit during blanking.
    mode = 2;
    for (int i = 0; i < 6400; i++) step(1'b0, 1'b0, 0, 0);

    // Lit and out-of-bounds together: lit wins.
    mode = 3;
    probe_h = 300; probe_v = mv + 1; probe_rgb = 12'hEEE;
    for (int i = 0; i < 2400; i++) step(1'b0, 1'b0, 0, 0);
    check("lit_over_oob", 32'(probe_rgb), 32'(FG));

    // Bottom-right visible corner and vertical sync.
    clear_stats();
    mode = 2;
    step(1'b0, 1'b1, 600, 478);
    j = cyc;
    for (int i = 0; i < 13800; i++) step(1'b0, 1'b0, 0, 0);
    check("last_visible_addr", 32'(addr_seen), 32'(corner));
    check("vsync_first_low", 32'(vs_first), 32'(j + 9002));
    check("vsync_low_two_lines", 32'(vs_cnt), 32'd1600);

    // Frame wrap: exactly one more frame_start, a full frame period after the first.
    step(1'b0, 1'b1, 790, 524);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 0, 0);
    check("frame_start_count", 32'(fs_n), 32'd2);
    check("frame_period", 32'(fs_vt[1] - fs_vt[0]), 32'd420000);

    // Mid-frame reset at (300,200).
    step(1'b0, 1'b1, 290, 200);
    for (int i = 0; i < 20 && !(mh == 300 && mv == 200); i++) step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    rel2 = cyc + 1;
    step(1'b0, 1'b0, 0, 0);
    check("midrst_addr", 32'(addr_last), 32'd0);
    check("midrst_hsync", 32'(vga_hsync), 32'd1);
    check("midrst_vsync", 32'(vga_vsync), 32'd1);
    check("midrst_rgb", 32'(vga_rgb), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);
    check("midrst_frame_start", 32'(fs_cyc), 32'(rel2 + 2));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
